// File: rtl/rb_window_stream_if.sv
// Pixel-in / column-out stream bundle for rb_window_stream.
// master = producer/consumer side, slave = the window generator.
interface rb_window_stream_if #(
    parameter int PIXEL_WIDTH = 8,
    parameter int K           = 3,
    parameter int IMG_WIDTH   = 128,
    parameter int IMG_HEIGHT  = 128
);
    localparam int XW = $clog2(IMG_WIDTH);
    localparam int YW = $clog2(IMG_HEIGHT);

    logic                     in_valid;
    logic                     in_ready;
    logic [PIXEL_WIDTH-1:0]   in_pixel;
    logic                     in_sof;
    logic                     out_valid;
    logic                     out_ready;
    logic [K*PIXEL_WIDTH-1:0] out_col;
    logic [XW-1:0]            out_x;
    logic [YW-1:0]            out_y;
    logic                     out_eof;

    modport master (
        output in_valid, in_pixel, in_sof, out_ready,
        input  in_ready, out_valid, out_col, out_x, out_y, out_eof
    );

    modport slave (
        input  in_valid, in_pixel, in_sof, out_ready,
        output in_ready, out_valid, out_col, out_x, out_y, out_eof
    );
endinterface

// File: rtl/rb_window_stream.sv
// Streaming K-row vertical column generator: buffers K-1 previous rows in
// per-lane RAMs and emits {current, row-1, ..., row-K+1} for every pixel.
module rb_window_stream #(
    parameter int PIXEL_WIDTH = 8,
    parameter int K           = 3,
    parameter int IMG_WIDTH   = 128,
    parameter int IMG_HEIGHT  = 128
) (
    input  logic              clk,
    input  logic              rst,
    rb_window_stream_if.slave s
);
    localparam int XW    = $clog2(IMG_WIDTH);
    localparam int YW    = $clog2(IMG_HEIGHT);
    localparam int PW    = PIXEL_WIDTH;
    localparam int LANES = K - 1;
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;

    localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);
    localparam logic [YW-1:0] Y_PRIM = YW'(K - 1);
    localparam logic [LW-1:0] L_LAST = LW'(LANES - 1);

    logic [XW-1:0] x_reg, x_next, x_eff;
    logic [YW-1:0] y_reg, y_next, y_eff;
    logic [LW-1:0] lane_reg, lane_next, lane_eff;

    logic          s1_valid_reg;
    logic [PW-1:0] s1_pixel_reg;
    logic [XW-1:0] s1_x_reg;
    logic [YW-1:0] s1_y_reg;
    logic [LW-1:0] s1_lane_reg;

    logic              out_valid_reg;
    logic [K*PW-1:0]   out_col_reg;
    logic [XW-1:0]     out_x_reg;
    logic [YW-1:0]     out_y_reg;
    logic              out_eof_reg;

    logic              adv;
    logic              accept;
    logic [LANES*PW-1:0] rd_flat;
    logic [LANES*PW-1:0] rot_data;

    // The whole pipe advances only when the output slot is free or draining.
    assign adv        = !out_valid_reg || s.out_ready;
    assign s.in_ready = adv && !rst;
    assign accept     = s.in_valid && adv && !rst;

    // A start-of-frame pixel overrides the raster counters.
    assign x_eff    = s.in_sof ? '0 : x_reg;
    assign y_eff    = s.in_sof ? '0 : y_reg;
    assign lane_eff = s.in_sof ? '0 : lane_reg;

    always_comb begin
        x_next    = x_reg;
        y_next    = y_reg;
        lane_next = lane_reg;
        if (accept) begin
            if (x_eff == X_LAST) begin
                x_next = '0;
                if (y_eff == Y_LAST) begin
                    y_next    = '0;
                    lane_next = '0;
                end else begin
                    y_next    = y_eff + YW'(1);
                    lane_next = (lane_eff == L_LAST) ? '0 : lane_eff + LW'(1);
                end
            end else begin
                x_next    = x_eff + XW'(1);
                y_next    = y_eff;
                lane_next = lane_eff;
            end
        end
    end

    // Row buffer lanes: read-first, so the write of the new row returns the row it replaces.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic [PW-1:0] mem [IMG_WIDTH];
            logic [PW-1:0] rd_reg;

            always_ff @(posedge clk) begin
                if (accept) begin
                    rd_reg <= mem[x_eff];
                    if (lane_eff == LW'(gi)) begin
                        mem[x_eff] <= s.in_pixel;
                    end
                end
            end

            assign rd_flat[gi*PW +: PW] = rd_reg;
        end
    endgenerate

    // Rotate lanes so the lane being overwritten (oldest row) lands in the lowest slice.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_rot
            logic [LW:0]   sum;
            logic [LW-1:0] sel;

            assign sum = {1'b0, s1_lane_reg} + (LW+1)'(gi);
            assign sel = (sum >= (LW+1)'(LANES)) ? LW'(sum - (LW+1)'(LANES)) : sum[LW-1:0];
            assign rot_data[gi*PW +: PW] = rd_flat[sel*PW +: PW];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (accept) begin
            s1_pixel_reg <= s.in_pixel;
            s1_x_reg     <= x_eff;
            s1_y_reg     <= y_eff;
            s1_lane_reg  <= lane_eff;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_reg         <= '0;
            y_reg         <= '0;
            lane_reg      <= '0;
            s1_valid_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            out_col_reg   <= '0;
            out_x_reg     <= '0;
            out_y_reg     <= '0;
            out_eof_reg   <= 1'b0;
        end else begin
            x_reg    <= x_next;
            y_reg    <= y_next;
            lane_reg <= lane_next;
            if (adv) begin
                s1_valid_reg  <= accept;
                // Priming rows never reach the consumer.
                out_valid_reg <= s1_valid_reg && (s1_y_reg >= Y_PRIM);
                out_col_reg   <= {s1_pixel_reg, rot_data};
                out_x_reg     <= s1_x_reg;
                out_y_reg     <= s1_y_reg;
                out_eof_reg   <= s1_valid_reg && (s1_x_reg == X_LAST) && (s1_y_reg == Y_LAST);
            end
        end
    end

    assign s.out_valid = out_valid_reg;
    assign s.out_col   = out_col_reg;
    assign s.out_x     = out_x_reg;
    assign s.out_y     = out_y_reg;
    assign s.out_eof   = out_eof_reg;

endmodule

// File: tb/tb_rb_window_stream.sv
// Bench for rb_window_stream: raster/image model with expected-output queue,
// directed frames (priming, order, stall, sof, reset) then randomized traffic.
module tb_rb_window_stream;
    localparam int PW = 8;
    localparam int K  = 3;
    localparam int W  = 4;
    localparam int H  = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rb_window_stream_if #(.PIXEL_WIDTH(PW), .K(K), .IMG_WIDTH(W), .IMG_HEIGHT(H)) bus ();

    rb_window_stream #(.PIXEL_WIDTH(PW), .K(K), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk (clk),
        .rst (rst),
        .s   (bus)
    );

    typedef struct {
        logic [23:0] col;
        int          x;
        int          y;
        logic        eof;
        int          acc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e, n;
    logic [7:0]  img [H][W];
    int          mx = 0, my = 0;
    int          cyc = 0;
    int          checks = 0, passes = 0;
    bit          lat_check = 1'b1, pat = 1'b1;
    bit          sof_pend = 1'b0;
    int          sof_skip = 0;
    int          ready_mode = 0, stall_cnt = 0;
    bit          prev_stall = 1'b0;
    logic [23:0] held_col;
    logic [1:0]  held_x, held_y;
    logic        held_eof;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        else passes++;
    endtask

    task automatic fail_line(input string name);
        checks++;
        $display("FAIL %s: got no event expected event (cycle %0d)", name, cyc);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Model + compare, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            mx = 0;
            my = 0;
            prev_stall = 1'b0;
            sof_pend = 1'b0;
        end else begin
            chk("in_ready", {31'd0, bus.in_ready}, {31'd0, !bus.out_valid || bus.out_ready});
            if (prev_stall) begin
                chk("hold_col", {8'd0, bus.out_col}, {8'd0, held_col});
                chk("hold_xy", {28'd0, bus.out_x, bus.out_y}, {28'd0, held_x, held_y});
                chk("hold_eof_valid", {30'd0, bus.out_eof, bus.out_valid}, {30'd0, held_eof, 1'b1});
            end
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    fail_line("spurious_out");
                end else begin
                    e = exp_q[0];
                    chk("col", {8'd0, bus.out_col}, {8'd0, e.col});
                    chk("x", {30'd0, bus.out_x}, e.x);
                    chk("y", {30'd0, bus.out_y}, e.y);
                    chk("eof", {31'd0, bus.out_eof}, {31'd0, e.eof});
                    if (lat_check) chk("latency", cyc - e.acc, 2);
                    if (bus.out_ready) begin
                        void'(exp_q.pop_front());
                        if (pat && e.y == 2 && e.x == 1) chk("pin_col_21", {8'd0, bus.out_col}, 32'h211101);
                        if (pat && e.y == 3 && e.x == 2) chk("pin_col_32", {8'd0, bus.out_col}, 32'h322212);
                        if (pat && e.y == 3 && e.x == 3) begin
                            chk("pin_col_33", {8'd0, bus.out_col}, 32'h332313);
                            chk("pin_eof_33", {31'd0, bus.out_eof}, 32'd1);
                        end
                        if (sof_pend) begin
                            if (sof_skip > 0) sof_skip--;
                            else begin
                                chk("sof_next_x", {30'd0, bus.out_x}, 32'd0);
                                chk("sof_next_y", {30'd0, bus.out_y}, 32'd2);
                                sof_pend = 1'b0;
                            end
                        end
                    end
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            held_col = bus.out_col;
            held_x   = bus.out_x;
            held_y   = bus.out_y;
            held_eof = bus.out_eof;

            if (bus.in_valid && bus.in_ready) begin
                if (bus.in_sof) begin
                    mx = 0;
                    my = 0;
                    sof_pend = 1'b1;
                    sof_skip = exp_q.size();
                end
                img[my][mx] = bus.in_pixel;
                if (my >= K - 1) begin
                    n.col = {img[my][mx], img[my-1][mx], img[my-2][mx]};
                    n.x   = mx;
                    n.y   = my;
                    n.eof = (mx == W - 1) && (my == H - 1);
                    n.acc = cyc;
                    exp_q.push_back(n);
                end
                mx++;
                if (mx == W) begin
                    mx = 0;
                    my++;
                    if (my == H) my = 0;
                end
            end
        end
    end

    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (stall_cnt > 0) begin
                bus.out_ready = 1'b0;
                stall_cnt--;
            end else if (ready_mode == 1) begin
                bus.out_ready = ($urandom_range(0, 3) != 0);
            end else begin
                bus.out_ready = 1'b1;
            end
        end
    end

    task automatic push_pixel(input logic [7:0] pix, input logic sof);
        int  tries = 0;
        bit  acc;
        bus.in_pixel = pix;
        bus.in_sof   = sof;
        bus.in_valid = 1'b1;
        do begin
            @(negedge clk);
            acc = bus.in_ready;
            tries++;
            @(posedge clk);
            #1;
        end while (!acc && tries < 100);
        if (!acc) fail_line("push_timeout");
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
    endtask

    task automatic send_pattern(input int first, input int last, input bit sof_first);
        for (int i = first; i <= last; i++) begin
            push_pixel(8'((i / W) * 16 + (i % W)), sof_first && (i == first));
        end
    endtask

    task automatic drain();
        int waited = 0;
        while (exp_q.size() != 0 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (exp_q.size() != 0) fail_line("drain_timeout");
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        bus.in_pixel = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("in_ready_in_reset", {31'd0, bus.in_ready}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_out_col", {8'd0, bus.out_col}, 32'd0);
        chk("rst_out_xy_eof", {27'd0, bus.out_x, bus.out_y, bus.out_eof}, 32'd0);
        @(posedge clk);
        #1;

        // Priming, column order, lane rotation, eof.
        send_pattern(0, 15, 1'b0);
        drain();

        // Backpressure in row 2.
        lat_check = 1'b0;
        send_pattern(0, 9, 1'b1);
        stall_cnt = 3;
        send_pattern(10, 15, 1'b0);
        drain();
        lat_check = 1'b1;

        // Mid-frame sof at (2,1) restarts a fresh frame.
        send_pattern(0, 8, 1'b1);
        send_pattern(0, 15, 1'b1);
        drain();

        // Reset at (3,2), then a clean frame must reproduce the pinned values.
        send_pattern(0, 13, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk("in_ready_rst_pulse", {31'd0, bus.in_ready}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("post_rst_col", {8'd0, bus.out_col}, 32'd0);
        @(posedge clk);
        #1;
        send_pattern(0, 15, 1'b0);
        drain();

        // Randomized traffic: gaps, backpressure, stray sof, random data.
        pat        = 1'b0;
        lat_check  = 1'b0;
        ready_mode = 1;
        for (int f = 0; f < 8; f++) begin
            for (int i = 0; i < W * H; i++) begin
                repeat ($urandom_range(0, 2)) begin
                    bus.in_sof = 1'($urandom_range(0, 1));
                    @(posedge clk);
                    #1;
                end
                bus.in_sof = 1'b0;
                push_pixel(8'($urandom), (i == 0 && $urandom_range(0, 1) == 1) || ($urandom_range(0, 39) == 0));
            end
        end
        ready_mode = 0;
        drain();

        chk("queue_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
